// File: rtl/calfifo_pkg.sv
// calfifo_pkg
// Shared helpers for the write- and read-side pointer blocks of the
// clock-domain-crossing FIFO.
//   PTR_EXTRA_BITS : extra pointer bit beyond the address width. It lets a
//                    pointer tell a full FIFO apart from an empty one.
//   GRAY_MAX_W     : widest pointer the conversion helpers accept.
//   ptr_width()    : pointer width for a given address width.
//   bin2gray()     : binary-to-Gray conversion.
//   gray2bin()     : Gray-to-binary conversion (prefix XOR from the MSB).
// Pass narrower pointers zero-extended to GRAY_MAX_W and truncate the result.
// Zero bits above the real MSB do not change either conversion.
package calfifo_pkg;

    localparam int PTR_EXTRA_BITS = 1;
    localparam int GRAY_MAX_W     = 16;

    function automatic int ptr_width(input int addr_width);
        return addr_width + PTR_EXTRA_BITS;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/calfifo_gray2bin.sv
// calfifo_gray2bin
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits from the MSB down to that bit.
//   WIDTH : pointer width
//   gray  : Gray-coded input
//   bin   : binary equivalent
module calfifo_gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign bin[gi] = ^gray[WIDTH-1:gi];
    end

endmodule

// File: rtl/calfifo_wptr_tx.sv
// calfifo_wptr_tx
// Write-side pointer and flag logic of the clock-domain-crossing FIFO.
// The module keeps a binary write pointer. It launches that pointer in Gray
// code to the read domain. It also produces full, almost_full and fill-level
// flags from the read pointer, which arrives already synchronized.
//   clk            : write-domain clock
//   arst           : asynchronous active-high reset
//   srst           : synchronous active-high clear, same effect as arst
//   wr_en          : write request
//   rptr_gray_sync : Gray read pointer, already synchronized into clk
//   wr_addr        : RAM write address (low bits of the binary pointer)
//   wr_ack         : write accepted this cycle (RAM write strobe)
//   wptr_gray      : registered Gray write pointer
//   full           : registered full flag
//   almost_full    : registered flag, fill level >= AFULL_THRESH
//   wr_count       : registered fill level, 0 .. 2^ADDRWIDTH
//   overflow       : sticky write-while-full flag. This port exists only
//                    when CALFIFO_WR_OVERFLOW_EN is defined.
// ADDRWIDTH must be at least 2.
module calfifo_wptr_tx
    import calfifo_pkg::*;
#(
    parameter int ADDRWIDTH    = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 srst,
    input  logic                 wr_en,
    input  logic [ADDRWIDTH:0]   rptr_gray_sync,
    output logic [ADDRWIDTH-1:0] wr_addr,
    output logic                 wr_ack,
    output logic [ADDRWIDTH:0]   wptr_gray,
    output logic                 full,
    output logic                 almost_full,
`ifdef CALFIFO_WR_OVERFLOW_EN
    output logic [ADDRWIDTH:0]   wr_count,
    output logic                 overflow
`else
    output logic [ADDRWIDTH:0]   wr_count
`endif
);

    localparam int PTR_W = ptr_width(ADDRWIDTH);
    localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_THRESH);

    logic [PTR_W-1:0] wbin_reg;
    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] wgray_reg;
    logic [PTR_W-1:0] wgray_next;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] full_gray;
    logic [PTR_W-1:0] count_reg;
    logic [PTR_W-1:0] count_next;
    logic             full_reg;
    logic             full_next;
    logic             afull_reg;
    logic             afull_next;
    logic             wr_accept;

    calfifo_gray2bin #(
        .WIDTH (PTR_W)
    ) u_rptr_g2b (
        .gray (rptr_gray_sync),
        .bin  (rbin)
    );

    // While either reset is active, no write is accepted. This keeps the
    // RAM from being written during a clear.
    assign wr_accept = wr_en & ~full_reg & ~srst & ~arst;
    assign wbin_next = wbin_reg + PTR_W'(wr_accept);

    assign wgray_next = PTR_W'(bin2gray(GRAY_MAX_W'(wbin_next)));

    // In Gray code, the write pointer is exactly one depth ahead of the read
    // pointer when it equals the read pointer with its two top bits inverted.
    assign full_gray  = {~rptr_gray_sync[PTR_W-1 -: 2], rptr_gray_sync[PTR_W-3:0]};
    assign full_next  = (wgray_next == full_gray);

    // The subtraction wraps modulo 2^PTR_W, which gives the fill level
    // across pointer wraparound.
    assign count_next = wbin_next - rbin;
    assign afull_next = (count_next >= AFULL_LVL);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wbin_reg  <= '0;
            wgray_reg <= '0;
            count_reg <= '0;
            full_reg  <= 1'b0;
            afull_reg <= 1'b0;
        end else if (srst) begin
            wbin_reg  <= '0;
            wgray_reg <= '0;
            count_reg <= '0;
            full_reg  <= 1'b0;
            afull_reg <= 1'b0;
        end else begin
            wbin_reg  <= wbin_next;
            wgray_reg <= wgray_next;
            count_reg <= count_next;
            full_reg  <= full_next;
            afull_reg <= afull_next;
        end
    end

    assign wr_addr     = wbin_reg[ADDRWIDTH-1:0];
    assign wr_ack      = wr_accept;
    assign wptr_gray   = wgray_reg;
    assign full        = full_reg;
    assign almost_full = afull_reg;
    assign wr_count    = count_reg;

`ifdef CALFIFO_WR_OVERFLOW_EN
    logic overflow_reg;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            overflow_reg <= 1'b0;
        end else if (srst) begin
            overflow_reg <= 1'b0;
        end else if (wr_en && full_reg) begin
            overflow_reg <= 1'b1;
        end
    end

    assign overflow = overflow_reg;
`endif

endmodule

// File: tb/tb_calfifo_wptr_tx.sv
// tb_calfifo_wptr_tx
// Directed bench for calfifo_wptr_tx with ADDRWIDTH=3 and AFULL_THRESH=6.
// The model counts accepted writes and the read position as plain integers.
// It derives every output from those two numbers. Literal checks in the
// stimulus pin the model against hand-computed values.
module tb_calfifo_wptr_tx;

    logic       clk;
    logic       arst;
    logic       srst;
    logic       wr_en;
    logic [3:0] rptr_gray_sync;
    logic [2:0] wr_addr;
    logic       wr_ack;
    logic [3:0] wptr_gray;
    logic       full;
    logic       almost_full;
    logic [3:0] wr_count;
`ifdef CALFIFO_WR_OVERFLOW_EN
    logic       overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int rd_total = 0;

    calfifo_wptr_tx #(
        .ADDRWIDTH    (3),
        .AFULL_THRESH (6)
    ) dut (
        .clk            (clk),
        .arst           (arst),
        .srst           (srst),
        .wr_en          (wr_en),
        .rptr_gray_sync (rptr_gray_sync),
        .wr_addr        (wr_addr),
        .wr_ack         (wr_ack),
        .wptr_gray      (wptr_gray),
        .full           (full),
        .almost_full    (almost_full),
`ifdef CALFIFO_WR_OVERFLOW_EN
        .wr_count       (wr_count),
        .overflow       (overflow)
`else
        .wr_count       (wr_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] gray_of(input int n);
        logic [3:0] b;
        b = n[3:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    assign rptr_gray_sync = gray_of(rd_total);

    // The model holds the total number of accepted writes since reset.
    // The fill level is that total minus the read position.
    int m_wr;
    int m_fill;
    bit m_full;
    bit m_af;
    bit m_ovf;

    function automatic int next_wr(input int wr_now, input bit full_now, input logic en);
        return wr_now + ((en && !full_now) ? 1 : 0);
    endfunction

    always @(posedge clk or posedge arst) begin
        if (arst || srst) begin
            m_wr   <= 0;
            m_fill <= 0;
            m_full <= 1'b0;
            m_af   <= 1'b0;
            m_ovf  <= 1'b0;
        end else begin
            m_wr   <= next_wr(m_wr, m_full, wr_en);
            m_fill <= (next_wr(m_wr, m_full, wr_en) - rd_total) & 15;
            m_full <= ((next_wr(m_wr, m_full, wr_en) - rd_total) & 15) == 8;
            m_af   <= ((next_wr(m_wr, m_full, wr_en) - rd_total) & 15) >= 6;
            if (wr_en && m_full) m_ovf <= 1'b1;
        end
    end

    // Compare process: the inputs change 2 time units after each rising
    // edge, so they are stable at every falling edge.
    always @(negedge clk) begin
        check("cyc_wr_addr", int'(wr_addr), m_wr & 7);
        check("cyc_wptr_gray", int'(wptr_gray), int'(gray_of(m_wr)));
        check("cyc_wr_count", int'(wr_count), m_fill);
        check("cyc_full", int'(full), int'(m_full));
        check("cyc_almost_full", int'(almost_full), int'(m_af));
        check("cyc_wr_ack", int'(wr_ack), int'(wr_en && !m_full && !srst && !arst));
`ifdef CALFIFO_WR_OVERFLOW_EN
        check("cyc_overflow", int'(overflow), int'(m_ovf));
`endif
        $display("t=%0t en=%0b ack=%0b addr=%0d wg=%b cnt=%0d full=%0b af=%0b rg=%b",
                 $time, wr_en, wr_ack, wr_addr, wptr_gray, wr_count, full, almost_full,
                 rptr_gray_sync);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0] prev_g;
        arst  = 1'b1;
        srst  = 1'b0;
        wr_en = 1'b0;
        cyc();
        cyc();
        arst = 1'b0;
        cyc();
        check("reset_wptr_gray", int'(wptr_gray), 0);
        check("reset_wr_count", int'(wr_count), 0);
        check("reset_full", int'(full), 0);

        // Fill an empty FIFO with eight consecutive writes.
        wr_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check("fill_count", int'(wr_count), k);
            if (k == 5) check("fill_af_before", int'(almost_full), 0);
            if (k == 6) check("fill_af_at6", int'(almost_full), 1);
            if (k == 7) check("fill_full_before", int'(full), 0);
            if (k == 8) begin
                check("fill_full_at8", int'(full), 1);
                check("fill_gray_at8", int'(wptr_gray), 4'b1100);
            end
        end

        // Overrun: wr_en stays high for three cycles while the FIFO is full.
        for (int k = 0; k < 3; k++) begin
            check("ovr_ack", int'(wr_ack), 0);
            check("ovr_addr", int'(wr_addr), 0);
            cyc();
            check("ovr_gray", int'(wptr_gray), 4'b1100);
        end
`ifdef CALFIFO_WR_OVERFLOW_EN
        check("ovr_sticky", int'(overflow), 1);
`endif

        // Drain: the read pointer jumps to binary 3 (Gray 0010).
        wr_en    = 1'b0;
        rd_total = 3;
        cyc();
        check("drain_full", int'(full), 0);
        check("drain_count", int'(wr_count), 5);
        check("drain_af", int'(almost_full), 0);
`ifdef CALFIFO_WR_OVERFLOW_EN
        check("drain_ovf_sticky", int'(overflow), 1);
`endif

        // Write up to a fill level of 7. Then write and advance the read
        // pointer in the same cycle.
        wr_en = 1'b1;
        cyc();
        cyc();
        check("sim_pre_count", int'(wr_count), 7);
        rd_total = 4;
        cyc();
        check("sim_count", int'(wr_count), 7);
        check("sim_full", int'(full), 0);

        // Assert arst asynchronously in the middle of writing.
        #1 arst = 1'b1;
        #1;
        check("arst_gray", int'(wptr_gray), 0);
        check("arst_count", int'(wr_count), 0);
        check("arst_af", int'(almost_full), 0);
        check("arst_addr", int'(wr_addr), 0);
        check("arst_ack", int'(wr_ack), 0);
        wr_en    = 1'b0;
        rd_total = 0;
        cyc();
        arst = 1'b0;
        cyc();
        wr_en = 1'b1;
        #1;
        check("rel_addr", int'(wr_addr), 0);
        check("rel_ack", int'(wr_ack), 1);
        cyc();
        wr_en = 1'b0;
        check("rel_gray", int'(wptr_gray), 4'b0001);

        // A synchronous clear discards the write that is pending with it.
        wr_en = 1'b1;
        srst  = 1'b1;
        #1;
        check("srst_ack", int'(wr_ack), 0);
        cyc();
        srst  = 1'b0;
        wr_en = 1'b0;
        check("srst_gray", int'(wptr_gray), 0);
        check("srst_addr", int'(wr_addr), 0);
        cyc();

        // Wrap: sixteen writes, with the read pointer following the writes.
        prev_g = wptr_gray;
        wr_en  = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            rd_total = i - 1;
            cyc();
            check("wrap_onebit", $countones(wptr_gray ^ prev_g), 1);
            prev_g = wptr_gray;
            if (i == 7)  check("wrap_addr7", int'(wr_addr), 7);
            if (i == 8)  check("wrap_addr0", int'(wr_addr), 0);
            if (i == 15) check("wrap_gray15", int'(wptr_gray), 4'b1000);
            if (i == 16) check("wrap_gray16", int'(wptr_gray), 4'b0000);
        end
        wr_en = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
